// File: rtl/pc_fetch_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary.
// The IF/ID record layout is common to the fetch stage and the decode-side hazard logic.
package pc_fetch_pkg;

    localparam int PC_W    = 7;
    localparam int INSTR_W = 32;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] HALT_OPC = 6'h3F;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               valid;
    } if_id_t;

endpackage

// File: rtl/pc_fetch_if_id_reg.sv
// IF/ID pipeline register with flush and hold controls.
// Flush wins over hold and only clears valid; the payload is left as-is.
module if_id_reg
    import pc_fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   flush,
    input  logic   load,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t entry_q;
    if_id_t entry_d;

    // Neither load nor hold means the stage has nothing new, so the entry becomes a bubble.
    always_comb begin
        entry_d = entry_q;
        if (flush) begin
            entry_d.valid = 1'b0;
        end else if (hold) begin
            entry_d = entry_q;
        end else if (load) begin
            entry_d = d;
        end else begin
            entry_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q = entry_q;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, selects incrementer or branch target,
// loads IF/ID and handles stall, branch flush and halt.
//
// state | meaning
// RUN   | fetching one instruction per cycle
// STALL | hazard freeze; PC and IF/ID held
// HALT  | halt opcode fetched; PC parked until a branch or reset
module pc_fetch #(
    parameter int          INSTR_W  = 32,
    parameter int          OPC_MSB  = 31,
    parameter int          OPC_LSB  = 26,
    parameter logic [5:0]  HALT_OPC = 6'h3F
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         pc_inc,
    input  logic               branch_taken,
    input  logic [6:0]         branch_target,
    input  logic               stall,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [6:0]         pc,
    output logic               inc_en,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [6:0]         if_id_pc,
    output logic               if_id_valid,
    output logic               halted
);
    import pc_fetch_pkg::if_id_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [6:0]   pc_q;
    logic [6:0]   pc_d;
    logic         inc_en_q;
    logic         inc_en_d;

    logic   ifid_hold;
    logic   ifid_flush;
    logic   ifid_load;
    logic   is_halt;
    if_id_t ifid_d;
    if_id_t ifid_q;

    assign is_halt = (imem_rdata[OPC_MSB:OPC_LSB] == HALT_OPC);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        ifid_load  = 1'b0;
        if (branch_taken) begin
            pc_d       = branch_target;
            ifid_flush = 1'b1;
            state_d    = ST_RUN;
        end else if (stall) begin
            ifid_hold = 1'b1;
            if (state_q == ST_RUN) begin
                state_d = ST_STALL;
            end
        end else if (state_q == ST_HALT) begin
            state_d = ST_HALT;
        end else begin
            // Leaving STALL fetches in the same cycle, exactly like RUN.
            ifid_load = 1'b1;
            if (is_halt) begin
                state_d = ST_HALT;
            end else begin
                pc_d    = pc_inc;
                state_d = ST_RUN;
            end
        end
        inc_en_d = (state_d != ST_HALT);
    end

    always_comb begin
        ifid_d       = '0;
        ifid_d.instr = imem_rdata;
        ifid_d.pc    = pc_q;
        ifid_d.valid = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= '0;
            inc_en_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inc_en_q <= inc_en_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (ifid_hold),
        .flush (ifid_flush),
        .load  (ifid_load),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign pc          = pc_q;
    assign inc_en      = inc_en_q;
    assign halted      = (state_q == ST_HALT);
    assign if_id_instr = ifid_q.instr;
    assign if_id_pc    = ifid_q.pc;
    assign if_id_valid = ifid_q.valid;

endmodule
